// File: rtl/adc_controller.sv
// ATmega32U4-style ADC register block: ADCSRA/ADMUX, prescaled conversion sequencing, ADCL/ADCH result.
// Optional free-running auto trigger is enabled by defining ADC_AUTO_TRIGGER_EN.
module adc_controller #(
    parameter int CONV_CYCLES       = 13,
    parameter int FIRST_CONV_CYCLES = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] addr,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [7:0] joystick_analog,
    input  logic [7:0] entropy,
    output logic       adc_irq,
    input  logic       irq_ack
);

    typedef enum logic [1:0] {OFF, IDLE, CONV} state_t;

    state_t      state, state_next;
    logic        aden, adif, adie, adate;
    logic [2:0]  adps;
    logic [7:0]  admux;
    logic        first_conv;
    logic [6:0]  presc;
    logic [4:0]  tick_cnt;
    logic [4:0]  conv_mux;
    logic [9:0]  sample, result, chan_value;
    logic        read_lock;
    logic [7:0]  div_m1;
    logic [4:0]  conv_last;
    logic        wr_adcsra, wr_admux, tick, done, restart, start;

    assign wr_adcsra = wr && (addr == 8'h7A);
    assign wr_admux  = wr && (addr == 8'h7C);
    assign div_m1    = (adps == 3'd0) ? 8'd1 : (8'd1 << adps) - 8'd1;
    assign conv_last = first_conv ? 5'(FIRST_CONV_CYCLES - 1) : 5'(CONV_CYCLES - 1);
    assign tick      = (state == CONV) && (presc == div_m1[6:0]);
    assign done      = tick && (tick_cnt == conv_last);
    assign restart   = done && adate;
    assign adc_irq   = adif && adie;

`ifndef ADC_AUTO_TRIGGER_EN
    assign adate = 1'b0;
`endif

    always_comb begin
        case (conv_mux)
            5'h00:   chan_value = {~joystick_analog[7], joystick_analog[6:0], 2'b00};
            5'h1F:   chan_value = 10'h000;
            default: chan_value = {entropy, entropy[1:0]};
        endcase
    end

    // A write clearing ADEN overrides everything, aborting any conversion in flight.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            OFF: if (wr_adcsra && din[7]) begin
                state_next = din[6] ? CONV : IDLE;
                start      = din[6];
            end
            IDLE: if (wr_adcsra && din[6]) begin
                state_next = CONV;
                start      = 1'b1;
            end
            CONV: if (done && !restart) state_next = IDLE;
            default: state_next = OFF;
        endcase
        if (wr_adcsra && !din[7]) begin
            state_next = OFF;
            start      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= OFF;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aden       <= 1'b0;
            adie       <= 1'b0;
            adps       <= 3'd0;
            admux      <= 8'h00;
            first_conv <= 1'b0;
            presc      <= 7'd0;
            tick_cnt   <= 5'd0;
            conv_mux   <= 5'd0;
            sample     <= 10'h000;
            result     <= 10'h000;
            read_lock  <= 1'b0;
            adif       <= 1'b0;
        end else begin
            if (wr_adcsra) begin
                aden <= din[7];
                adie <= din[3];
                adps <= din[2:0];
                if (!aden && din[7]) first_conv <= 1'b1;
            end
            if (wr_admux) admux <= din;

            // Channel is latched at start so ADMUX writes mid-conversion only affect the next one.
            if (start || restart) begin
                presc    <= 7'd0;
                tick_cnt <= 5'd0;
                conv_mux <= admux[4:0];
            end else if (tick) begin
                presc    <= 7'd0;
                tick_cnt <= tick_cnt + 5'd1;
            end else if (state == CONV) begin
                presc    <= presc + 7'd1;
            end

            if (tick && tick_cnt == 5'd0) sample <= chan_value;

            if (done) begin
                first_conv <= 1'b0;
                if (!read_lock) result <= sample;
            end

            // Completion beats both clear paths when they coincide.
            if (done)                              adif <= 1'b1;
            else if (irq_ack || (wr_adcsra && din[4])) adif <= 1'b0;

            if (rd && addr == 8'h78)      read_lock <= 1'b1;
            else if (rd && addr == 8'h79) read_lock <= 1'b0;
        end
    end

`ifdef ADC_AUTO_TRIGGER_EN
    always_ff @(posedge clk) begin
        if (rst)            adate <= 1'b0;
        else if (wr_adcsra) adate <= din[5];
    end
`endif

    // ADLAR is applied at read time so flipping it re-presents the held result.
    always_comb begin
        dout = 8'h00;
        case (addr)
            8'h78: dout = admux[5] ? {result[1:0], 6'b0} : result[7:0];
            8'h79: dout = admux[5] ? result[9:2] : {6'b0, result[9:8]};
            8'h7A: dout = {aden, state == CONV, adate, adif, adie, adps};
            8'h7C: dout = admux;
            default: dout = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_adc_controller.sv
// Directed self-checking bench for adc_controller; timing windows and results are hand-computed.
module tb_adc_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] addr;
    logic       rd;
    logic       wr;
    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] joystick_analog;
    logic [7:0] entropy;
    logic       adc_irq;
    logic       irq_ack;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [7:0] obs;

    adc_controller dut (
        .clk             (clk),
        .rst             (rst),
        .addr            (addr),
        .rd              (rd),
        .wr              (wr),
        .din             (din),
        .dout            (dout),
        .joystick_analog (joystick_analog),
        .entropy         (entropy),
        .adc_irq         (adc_irq),
        .irq_ack         (irq_ack)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d);
        addr = a;
        din  = d;
        wr   = 1'b1;
        @(negedge clk);
        wr   = 1'b0;
    endtask

    task automatic readReg(input logic [7:0] a, output logic [7:0] v);
        addr = a;
        rd   = 1'b1;
        #1 v = dout;
        @(negedge clk);
        rd   = 1'b0;
    endtask

    task automatic peekReg(input logic [7:0] a, output logic [7:0] v);
        addr = a;
        #1 v = dout;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; addr = 8'h00; rd = 1'b0; wr = 1'b0; din = 8'h00;
        joystick_analog = 8'h00; entropy = 8'h00; irq_ack = 1'b0;
        waitCycles(3);
        rst = 1'b0;

        // Reset state
        peekReg(8'h7A, obs); checkOutput("rst_adcsra", obs, 8'h00);
        peekReg(8'h7C, obs); checkOutput("rst_admux", obs, 8'h00);
        peekReg(8'h78, obs); checkOutput("rst_adcl", obs, 8'h00);
        peekReg(8'h79, obs); checkOutput("rst_adch", obs, 8'h00);
        checkOutput("rst_irq", {7'b0, adc_irq}, 8'h00);
        peekReg(8'h7B, obs); checkOutput("unowned_addr", obs, 8'h00);

        // First conversion: 25 ticks at divisor 2 -> 50 cycles, joystick 0x40 -> 0x300
        joystick_analog = 8'h40;
        applyStimulus(8'h7C, 8'h00);
        applyStimulus(8'h7A, 8'hC8);
        waitCycles(49);
        peekReg(8'h7A, obs); checkOutput("first_busy_49", obs, 8'hC8);
        checkOutput("first_irq_49", {7'b0, adc_irq}, 8'h00);
        waitCycles(1);
        peekReg(8'h7A, obs); checkOutput("first_done_50", obs, 8'h98);
        checkOutput("first_irq_50", {7'b0, adc_irq}, 8'h01);
        readReg(8'h78, obs); checkOutput("first_adcl", obs, 8'h00);
        readReg(8'h79, obs); checkOutput("first_adch", obs, 8'h03);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        peekReg(8'h7A, obs); checkOutput("ack_clears_adif", obs, 8'h88);
        checkOutput("ack_irq_low", {7'b0, adc_irq}, 8'h00);

        // ADPS=7 normal conversion: 13*128 = 1664 cycles; input change after first tick ignored
        joystick_analog = 8'h80;
        applyStimulus(8'h7A, 8'hC7);
        waitCycles(300);
        joystick_analog = 8'h7F;
        waitCycles(1363);
        peekReg(8'h7A, obs); checkOutput("div128_busy_1663", obs, 8'hC7);
        waitCycles(1);
        peekReg(8'h7A, obs); checkOutput("div128_done_1664", obs, 8'h97);
        peekReg(8'h78, obs); checkOutput("div128_adcl", obs, 8'h00);
        peekReg(8'h79, obs); checkOutput("div128_adch", obs, 8'h00);

        // Left-adjusted result: joystick 0x7F -> 0x3FC
        applyStimulus(8'h7C, 8'h20);
        applyStimulus(8'h7A, 8'hD0);
        waitCycles(25);
        peekReg(8'h7A, obs); checkOutput("adlar_busy_25", obs, 8'hC0);
        waitCycles(1);
        peekReg(8'h7A, obs); checkOutput("adlar_done_26", obs, 8'h90);
        readReg(8'h78, obs); checkOutput("adlar_adcl", obs, 8'h00);
        readReg(8'h79, obs); checkOutput("adlar_adch", obs, 8'hFF);
        applyStimulus(8'h7C, 8'h00);
        peekReg(8'h79, obs); checkOutput("represent_adch", obs, 8'h03);
        peekReg(8'h78, obs); checkOutput("represent_adcl", obs, 8'hFC);

        // Read lock: completion while locked sets ADIF but drops the result
        readReg(8'h78, obs); checkOutput("lock_adcl", obs, 8'hFC);
        joystick_analog = 8'h00;
        applyStimulus(8'h7A, 8'hD0);
        waitCycles(26);
        peekReg(8'h7A, obs); checkOutput("locked_adif", obs, 8'h90);
        peekReg(8'h79, obs); checkOutput("locked_adch_old", obs, 8'h03);
        peekReg(8'h78, obs); checkOutput("locked_adcl_old", obs, 8'hFC);
        readReg(8'h79, obs); checkOutput("unlock_adch", obs, 8'h03);
        applyStimulus(8'h7A, 8'hD0);
        waitCycles(26);
        peekReg(8'h79, obs); checkOutput("unlocked_adch_new", obs, 8'h02);
        peekReg(8'h78, obs); checkOutput("unlocked_adcl_new", obs, 8'h00);

        // Completion coinciding with irq_ack, then with a write-1-to-clear
        applyStimulus(8'h7A, 8'hD8);
        waitCycles(25);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        peekReg(8'h7A, obs); checkOutput("done_vs_ack", obs, 8'h98);
        checkOutput("done_vs_ack_irq", {7'b0, adc_irq}, 8'h01);
        applyStimulus(8'h7A, 8'hD8);
        waitCycles(25);
        applyStimulus(8'h7A, 8'h98);
        peekReg(8'h7A, obs); checkOutput("done_vs_w1c", obs, 8'h98);

        // Abort mid-conversion, then re-enable for a 25-tick first conversion
        joystick_analog = 8'h40;
        applyStimulus(8'h7A, 8'hD0);
        waitCycles(10);
        applyStimulus(8'h7A, 8'h00);
        peekReg(8'h7A, obs); checkOutput("abort_adcsra", obs, 8'h00);
        waitCycles(40);
        peekReg(8'h7A, obs); checkOutput("abort_no_adif", obs, 8'h00);
        peekReg(8'h79, obs); checkOutput("abort_adch_kept", obs, 8'h02);
        applyStimulus(8'h7A, 8'hC0);
        waitCycles(49);
        peekReg(8'h7A, obs); checkOutput("reen_busy_49", obs, 8'hC0);
        waitCycles(1);
        peekReg(8'h7A, obs); checkOutput("reen_done_50", obs, 8'h90);
        peekReg(8'h79, obs); checkOutput("reen_adch", obs, 8'h03);

        // Entropy channel 0x05 with entropy 0xA5 -> 0x295
        applyStimulus(8'h7C, 8'h05);
        entropy = 8'hA5;
        applyStimulus(8'h7A, 8'h90);
        applyStimulus(8'h7A, 8'hE0);
`ifdef ADC_AUTO_TRIGGER_EN
        waitCycles(25);
        peekReg(8'h7A, obs); checkOutput("auto_busy_25", obs, 8'hE0);
        waitCycles(1);
        peekReg(8'h7A, obs); checkOutput("auto_done_26", obs, 8'hF0);
        peekReg(8'h79, obs); checkOutput("auto_adch", obs, 8'h02);
        peekReg(8'h78, obs); checkOutput("auto_adcl", obs, 8'h95);
        applyStimulus(8'h7A, 8'hF0);
        peekReg(8'h7A, obs); checkOutput("auto_cleared", obs, 8'hE0);
        waitCycles(24);
        peekReg(8'h7A, obs); checkOutput("auto_busy_51", obs, 8'hE0);
        waitCycles(1);
        peekReg(8'h7A, obs); checkOutput("auto_done_52", obs, 8'hF0);
        applyStimulus(8'h7A, 8'h90);
        peekReg(8'h7A, obs); checkOutput("auto_stop_running", obs, 8'hC0);
        waitCycles(24);
        peekReg(8'h7A, obs); checkOutput("auto_stop_busy_77", obs, 8'hC0);
        waitCycles(1);
        peekReg(8'h7A, obs); checkOutput("auto_stop_done_78", obs, 8'h90);
        waitCycles(30);
        peekReg(8'h7A, obs); checkOutput("auto_stopped", obs, 8'h90);
`else
        peekReg(8'h7A, obs); checkOutput("single_adate_0", obs, 8'hC0);
        waitCycles(26);
        peekReg(8'h7A, obs); checkOutput("single_done_26", obs, 8'h90);
        peekReg(8'h79, obs); checkOutput("single_adch", obs, 8'h02);
        peekReg(8'h78, obs); checkOutput("single_adcl", obs, 8'h95);
        waitCycles(30);
        peekReg(8'h7A, obs); checkOutput("single_no_restart", obs, 8'h90);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
